// File: rtl/ulpi_reg_arbiter.sv
// ULPI register-port arbiter. It writes the PHY init table, then serves two clients with round-robin arbitration.
// Latency: EN is issued 1 cycle after a grant, and ACK is pulsed 1 cycle after DONE. A failure or timeout re-issues after a 1-cycle gap.
// Backpressure: a client holds REQ until its ACK. The PHY stalls by withholding DONE, bounded by TIMEOUT.
module ulpi_reg_arbiter #(
    parameter int          MAX_RETRY      = 3,
    parameter int          TIMEOUT        = 255,
    parameter logic [7:0]  INIT_FUNC_CTRL = 8'h45,
    parameter logic [7:0]  INIT_OTG_CTRL  = 8'h00
) (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    input  logic       ULPI_READY,
    output logic       ULPI_REG_EN,
    output logic       ULPI_REG_RW,
    output logic [5:0] ULPI_REG_ADDR,
    output logic [7:0] ULPI_REG_WDATA,
    input  logic [7:0] ULPI_REG_RDATA,
    input  logic       ULPI_REG_DONE,
    input  logic       ULPI_REG_FAIL,
    input  logic       C0_REQ,
    input  logic       C0_RW,
    input  logic [5:0] C0_ADDR,
    input  logic [7:0] C0_WDATA,
    output logic       C0_ACK,
    output logic       C0_ERR,
    output logic [7:0] C0_RDATA,
    input  logic       C1_REQ,
    input  logic       C1_RW,
    input  logic [5:0] C1_ADDR,
    input  logic [7:0] C1_WDATA,
    output logic       C1_ACK,
    output logic       C1_ERR,
    output logic [7:0] C1_RDATA,
    output logic       INIT_DONE,
    output logic       INIT_ERR
);

    typedef enum logic [2:0] {
        WAIT_READY, INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT, GAP
    } state_t;

    localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);
    localparam logic [15:0] TMO_LIM   = 16'(TIMEOUT);

    state_t      state_q, state_d;
    state_t      gap_nxt_q, gap_nxt_d;     // where GAP hands over: re-issue, next init entry or IDLE
    logic        rw_q, rw_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  retry_q, retry_d;
    logic [15:0] tmo_q, tmo_d;
    logic        idx_q, idx_d;             // init table index
    logic        owner_q, owner_d;         // client owning the current access
    logic        prio_q, prio_d;           // client preferred on a tie
    logic        init_done_q, init_done_d;
    logic        init_err_q, init_err_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  rdata0_q, rdata0_d;
    logic [7:0]  rdata1_q, rdata1_d;

    logic        en;
    logic        acc_done;
    logic        acc_fail;
    logic        gnt;

    // A DONE that coincides with FAIL wins. A timeout fires TIMEOUT cycles after EN.
    assign acc_done = ULPI_REG_DONE;
    assign acc_fail = !ULPI_REG_DONE && (ULPI_REG_FAIL || ((tmo_q + 16'd1) == TMO_LIM));

    // Next-state, access latching, retry and completion bookkeeping.
    always_comb begin
        state_d     = state_q;
        gap_nxt_d   = gap_nxt_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        idx_d       = idx_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        ack_d       = 2'b00;
        err_d       = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        en          = 1'b0;
        gnt         = 1'b0;

        case (state_q)
            WAIT_READY: begin
                if (ULPI_READY) begin
                    state_d = INIT_ISSUE;
                    idx_d   = 1'b0;
                    retry_d = 8'd0;
                    rw_d    = 1'b1;
                    addr_d  = 6'h04;
                    wdata_d = INIT_FUNC_CTRL;
                end
            end
            INIT_ISSUE: begin
                en      = 1'b1;
                tmo_d   = 16'd0;
                state_d = INIT_WAIT;
            end
            INIT_WAIT: begin
                tmo_d = tmo_q + 16'd1;
                if (acc_done || acc_fail) begin
                    state_d = GAP;
                    if (acc_fail && (retry_q < RETRY_LIM)) begin
                        retry_d   = retry_q + 8'd1;
                        gap_nxt_d = INIT_ISSUE;
                    end else begin
                        if (acc_fail) begin
                            init_err_d = 1'b1;
                        end
                        if (idx_q) begin
                            init_done_d = 1'b1;
                            gap_nxt_d   = IDLE;
                        end else begin
                            idx_d     = 1'b1;
                            retry_d   = 8'd0;
                            rw_d      = 1'b1;
                            addr_d    = 6'h0A;
                            wdata_d   = INIT_OTG_CTRL;
                            gap_nxt_d = INIT_ISSUE;
                        end
                    end
                end
            end
            IDLE: begin
                if (C0_REQ || C1_REQ) begin
                    gnt     = (C0_REQ && C1_REQ) ? prio_q : C1_REQ;
                    owner_d = gnt;
                    prio_d  = ~gnt;
                    retry_d = 8'd0;
                    rw_d    = gnt ? C1_RW    : C0_RW;
                    addr_d  = gnt ? C1_ADDR  : C0_ADDR;
                    wdata_d = gnt ? C1_WDATA : C0_WDATA;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                en      = 1'b1;
                tmo_d   = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + 16'd1;
                if (acc_done || acc_fail) begin
                    state_d = GAP;
                    if (acc_fail && (retry_q < RETRY_LIM)) begin
                        retry_d   = retry_q + 8'd1;
                        gap_nxt_d = ISSUE;
                    end else begin
                        ack_d[owner_q] = 1'b1;
                        err_d[owner_q] = acc_fail;
                        if (acc_done && !rw_q) begin
                            if (owner_q) begin
                                rdata1_d = ULPI_REG_RDATA;
                            end else begin
                                rdata0_d = ULPI_REG_RDATA;
                            end
                        end
                        gap_nxt_d = IDLE;
                    end
                end
            end
            GAP: begin
                state_d = gap_nxt_q;
            end
            default: begin
                state_d = WAIT_READY;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any access in flight.
    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state_q     <= WAIT_READY;
            gap_nxt_q   <= IDLE;
            rw_q        <= 1'b0;
            addr_q      <= 6'd0;
            wdata_q     <= 8'd0;
            retry_q     <= 8'd0;
            tmo_q       <= 16'd0;
            idx_q       <= 1'b0;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= 8'd0;
            rdata1_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            gap_nxt_q   <= gap_nxt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign ULPI_REG_EN    = en;
    assign ULPI_REG_RW    = rw_q;
    assign ULPI_REG_ADDR  = addr_q;
    assign ULPI_REG_WDATA = wdata_q;
    assign C0_ACK         = ack_q[0];
    assign C0_ERR         = err_q[0];
    assign C0_RDATA       = rdata0_q;
    assign C1_ACK         = ack_q[1];
    assign C1_ERR         = err_q[1];
    assign C1_RDATA       = rdata1_q;
    assign INIT_DONE      = init_done_q;
    assign INIT_ERR       = init_err_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Bench for ulpi_reg_arbiter. A scripted PHY answers each EN, and monitors score the EN fields and client ACKs against queues.
// Latency: the PHY answers 3 cycles after EN with DONE or FAIL, or stays silent.
// Backpressure: clients hold REQ until their ACK is seen.
module tb_ulpi_reg_arbiter;

    logic       CLK_60M = 1'b0;
    logic       NRST_A_USB;
    logic       ULPI_READY;
    logic       ULPI_REG_EN, ULPI_REG_RW;
    logic [5:0] ULPI_REG_ADDR;
    logic [7:0] ULPI_REG_WDATA, ULPI_REG_RDATA;
    logic       ULPI_REG_DONE, ULPI_REG_FAIL;
    logic       C0_REQ, C0_RW, C0_ACK, C0_ERR;
    logic [5:0] C0_ADDR;
    logic [7:0] C0_WDATA, C0_RDATA;
    logic       C1_REQ, C1_RW, C1_ACK, C1_ERR;
    logic [5:0] C1_ADDR;
    logic [7:0] C1_WDATA, C1_RDATA;
    logic       INIT_DONE, INIT_ERR;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_cnt = 0;
    int fail_budget = 0;
    int silent_budget = 0;
    logic [7:0] phy_rdata = 8'h00;

    logic [14:0] en_q[$];      // {rw, addr, wdata}
    logic [9:0]  ack_q[$];     // {client, err, rdata}
    int          en_hist[$];

    ulpi_reg_arbiter dut (
        .CLK_60M(CLK_60M), .NRST_A_USB(NRST_A_USB), .ULPI_READY(ULPI_READY),
        .ULPI_REG_EN(ULPI_REG_EN), .ULPI_REG_RW(ULPI_REG_RW), .ULPI_REG_ADDR(ULPI_REG_ADDR),
        .ULPI_REG_WDATA(ULPI_REG_WDATA), .ULPI_REG_RDATA(ULPI_REG_RDATA),
        .ULPI_REG_DONE(ULPI_REG_DONE), .ULPI_REG_FAIL(ULPI_REG_FAIL),
        .C0_REQ(C0_REQ), .C0_RW(C0_RW), .C0_ADDR(C0_ADDR), .C0_WDATA(C0_WDATA),
        .C0_ACK(C0_ACK), .C0_ERR(C0_ERR), .C0_RDATA(C0_RDATA),
        .C1_REQ(C1_REQ), .C1_RW(C1_RW), .C1_ADDR(C1_ADDR), .C1_WDATA(C1_WDATA),
        .C1_ACK(C1_ACK), .C1_ERR(C1_ERR), .C1_RDATA(C1_RDATA),
        .INIT_DONE(INIT_DONE), .INIT_ERR(INIT_ERR)
    );

    always #5 CLK_60M = ~CLK_60M;

    always @(posedge CLK_60M) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] all_outputs();
        return {ULPI_REG_EN, ULPI_REG_RW, ULPI_REG_ADDR, ULPI_REG_WDATA,
                C0_ACK, C0_ERR, C0_RDATA, C1_ACK, C1_ERR, C1_RDATA, INIT_DONE, INIT_ERR};
    endfunction

    // Scripted PHY: answers 3 cycles after each EN.
    initial begin
        ULPI_REG_DONE = 1'b0;
        ULPI_REG_FAIL = 1'b0;
        ULPI_REG_RDATA = 8'h00;
        forever begin
            @(negedge CLK_60M);
            if (NRST_A_USB && ULPI_REG_EN) begin
                repeat (3) @(negedge CLK_60M);
                if (!NRST_A_USB) begin
                    ULPI_REG_DONE = 1'b0;
                end else if (silent_budget > 0) begin
                    silent_budget--;
                end else if (fail_budget > 0) begin
                    fail_budget--;
                    ULPI_REG_FAIL = 1'b1;
                end else begin
                    ULPI_REG_DONE = 1'b1;
                    ULPI_REG_RDATA = phy_rdata;
                end
                @(negedge CLK_60M);
                ULPI_REG_DONE = 1'b0;
                ULPI_REG_FAIL = 1'b0;
            end
        end
    end

    // EN monitor: each strobe must carry the next expected access.
    always @(negedge CLK_60M) begin
        if (NRST_A_USB && ULPI_REG_EN) begin
            en_cnt++;
            en_hist.push_back(cyc);
            if (en_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL en_unexpected observed=%0h expected=none",
                       {ULPI_REG_RW, ULPI_REG_ADDR, ULPI_REG_WDATA});
            end else begin
                check("en_fields", {ULPI_REG_RW, ULPI_REG_ADDR, ULPI_REG_WDATA}, en_q.pop_front());
            end
        end
    end

    // ACK monitor: each completion must match the next expected {client, err, rdata}.
    always @(negedge CLK_60M) begin
        if (NRST_A_USB && (C0_ACK || C1_ACK)) begin
            if (ack_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL ack_unexpected observed=%0h expected=none", {C1_ACK, C0_ACK});
            end else if (C0_ACK) begin
                check("ack_c0", {1'b0, C0_ERR, C0_RDATA}, ack_q.pop_front());
            end else begin
                check("ack_c1", {1'b1, C1_ERR, C1_RDATA}, ack_q.pop_front());
            end
        end
    end

    task automatic push_init(input logic [7:0] func_ctrl, input logic [7:0] otg_ctrl);
        en_q.push_back({1'b1, 6'h04, func_ctrl});
        en_q.push_back({1'b1, 6'h0A, otg_ctrl});
    endtask

    task automatic wait_init();
        for (int i = 0; i < 3000 && !INIT_DONE; i++) @(negedge CLK_60M);
        check("init_done", INIT_DONE, 1'b1);
        check("init_writes_drained", en_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge CLK_60M);
        NRST_A_USB = 1'b0;
        repeat (2) @(negedge CLK_60M);
        NRST_A_USB = 1'b1;
    endtask

    task automatic client_access(input logic n, input logic rw, input logic [5:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        if (n) begin C1_RW = rw; C1_ADDR = a; C1_WDATA = d; C1_REQ = 1'b1; end
        else   begin C0_RW = rw; C0_ADDR = a; C0_WDATA = d; C0_REQ = 1'b1; end
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge CLK_60M);
            got = n ? C1_ACK : C0_ACK;
        end
        C0_REQ = 1'b0;
        C1_REQ = 1'b0;
        check(n ? "c1_ack_seen" : "c0_ack_seen", got, 1'b1);
    endtask

    initial begin
        int base;
        int acks;
        NRST_A_USB = 1'b0;
        ULPI_READY = 1'b0;
        C0_REQ = 1'b1; C0_RW = 1'b0; C0_ADDR = 6'h00; C0_WDATA = 8'h00;
        C1_REQ = 1'b0; C1_RW = 1'b0; C1_ADDR = 6'h00; C1_WDATA = 8'h00;

        // Reset state, then no activity while READY is low, even though a client is requesting.
        repeat (3) @(negedge CLK_60M);
        check("reset_outputs", all_outputs(), 38'd0);
        NRST_A_USB = 1'b1;
        repeat (6) @(negedge CLK_60M);
        check("no_en_before_ready", en_cnt, 0);
        C0_REQ = 1'b0;

        // Init table with a PHY that answers DONE.
        push_init(8'h45, 8'h00);
        ULPI_READY = 1'b1;
        wait_init();
        check("init_err_clean", INIT_ERR, 1'b0);

        // C0 reads reg 0x00, and the PHY returns 0x24.
        phy_rdata = 8'h24;
        base = en_cnt;
        en_q.push_back({1'b0, 6'h00, 8'h00});
        ack_q.push_back({1'b0, 1'b0, 8'h24});
        client_access(1'b0, 1'b0, 6'h00, 8'h00);
        check("c0_read_single_en", en_cnt - base, 1);

        // C1 write: RDATA stays at its reset value.
        en_q.push_back({1'b1, 6'h16, 8'hA5});
        ack_q.push_back({1'b1, 1'b0, 8'h00});
        client_access(1'b1, 1'b1, 6'h16, 8'hA5);

        // C1 write that fails every attempt: 1 issue + 3 retries, then ACK with ERR.
        fail_budget = 99;
        base = en_cnt;
        for (int i = 0; i < 4; i++) en_q.push_back({1'b1, 6'h05, 8'h3C});
        ack_q.push_back({1'b1, 1'b1, 8'h00});
        client_access(1'b1, 1'b1, 6'h05, 8'h3C);
        fail_budget = 0;
        check("c1_fail_en_count", en_cnt - base, 4);

        // Both clients request continuously, so grants alternate starting with C0.
        phy_rdata = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            en_q.push_back({1'b0, 6'h11, 8'h00});
            en_q.push_back({1'b1, 6'h22, 8'h77});
            ack_q.push_back({1'b0, 1'b0, 8'h5A});
            ack_q.push_back({1'b1, 1'b0, 8'h00});
        end
        C0_RW = 1'b0; C0_ADDR = 6'h11; C0_WDATA = 8'h00;
        C1_RW = 1'b1; C1_ADDR = 6'h22; C1_WDATA = 8'h77;
        base = en_hist.size();
        C0_REQ = 1'b1;
        C1_REQ = 1'b1;
        acks = 0;
        for (int i = 0; i < 200 && acks < 4; i++) begin
            @(negedge CLK_60M);
            if (C0_ACK || C1_ACK) acks++;
        end
        C0_REQ = 1'b0;
        C1_REQ = 1'b0;
        check("rr_acks", acks, 4);
        check("rr_en_count", en_hist.size() - base, 4);
        // EN to DONE takes 3 cycles. GAP, IDLE and ISSUE follow, so EN-to-EN is 6 cycles.
        if (en_hist.size() - base == 4) begin
            for (int i = 1; i < 4; i++)
                check("rr_en_spacing", en_hist[base + i] - en_hist[base + i - 1], 6);
        end

        // Silent PHY: timeout TIMEOUT cycles after EN, one GAP, then the access is re-issued.
        silent_budget = 1;
        base = en_hist.size();
        en_q.push_back({1'b1, 6'h33, 8'h99});
        en_q.push_back({1'b1, 6'h33, 8'h99});
        ack_q.push_back({1'b0, 1'b0, 8'h5A});
        client_access(1'b0, 1'b1, 6'h33, 8'h99);
        check("tmo_en_count", en_hist.size() - base, 2);
        if (en_hist.size() - base == 2)
            check("tmo_reissue_gap", en_hist[base + 1] - en_hist[base], 255 + 2);

        // Reset restarts init. Two failures on entry 0 are recovered by retries.
        fail_budget = 2;
        for (int i = 0; i < 2; i++) en_q.push_back({1'b1, 6'h04, 8'h45});
        push_init(8'h45, 8'h00);
        do_reset();
        wait_init();
        check("init_retry_err", INIT_ERR, 1'b0);

        // Entry 0 exhausts its retries: INIT_ERR is set and init still finishes entry 1.
        fail_budget = 4;
        for (int i = 0; i < 3; i++) en_q.push_back({1'b1, 6'h04, 8'h45});
        push_init(8'h45, 8'h00);
        do_reset();
        wait_init();
        check("init_exhaust_err", INIT_ERR, 1'b1);
        fail_budget = 0;

        // Reset in the middle of a client WAIT: outputs clear at once, and init reruns from entry 0.
        silent_budget = 1;
        base = en_cnt;
        en_q.push_back({1'b0, 6'h07, 8'h00});
        C0_RW = 1'b0; C0_ADDR = 6'h07; C0_WDATA = 8'h00; C0_REQ = 1'b1;
        for (int i = 0; i < 50 && en_cnt == base; i++) @(negedge CLK_60M);
        check("midwait_en_seen", en_cnt - base, 1);
        repeat (2) @(negedge CLK_60M);
        #2 NRST_A_USB = 1'b0;
        #1 check("midwait_reset_outputs", all_outputs(), 38'd0);
        C0_REQ = 1'b0;
        silent_budget = 0;
        ack_q.delete();
        repeat (2) @(negedge CLK_60M);
        push_init(8'h45, 8'h00);
        NRST_A_USB = 1'b1;
        wait_init();
        check("midwait_init_err", INIT_ERR, 1'b0);

        repeat (4) @(negedge CLK_60M);
        check("en_queue_drained", en_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
